sixteen_bit_serial_adder: RTL

//  Multi-cycle signed adder, the add-direction counterpart of the 16-bit subtractor datapath.

---
 rtl/sixteen_bit_serial_adder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sixteen_bit_serial_adder.sv
// Digit-serial signed adder: sum = a + b + ci, DIGIT bits per cycle, with signed overflow flag.
// Optional build macro SERIAL_ADD_SATURATE_EN clamps the result to the signed range on overflow.
module sixteen_bit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_digit_check
        $error("sixteen_bit_serial_adder: DIGIT must divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_sh_q, a_sh_d;
    logic [WIDTH-1:0]     b_sh_q, b_sh_d;
    logic                 carry_q, carry_d;
    logic                 a_msb_q, a_msb_d;
    logic                 b_msb_q, b_msb_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 overflow_q, overflow_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [DIGIT:0]       digit_sum;
    logic [WIDTH-1:0]     a_next;
    logic                 ov_raw;
    logic [WIDTH-1:0]     result;

    // Result digits enter a_sh from the top as operand digits leave the bottom,
    // so after the last digit cycle a_sh holds the complete wrapped sum.
    always_comb begin
        digit_sum = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
                  + (DIGIT+1)'(carry_q);
        a_next    = (a_sh_q >> DIGIT)
                  | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        ov_raw    = (a_msb_q == b_msb_q) && (a_next[WIDTH-1] != a_msb_q);
        result    = a_next;
`ifdef SERIAL_ADD_SATURATE_EN
        if (ov_raw) begin
            result = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        carry_d     = carry_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        count_d     = count_q;
        sum_d       = sum_q;
        overflow_d  = overflow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    carry_d    = ci;
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = b[WIDTH-1];
                    count_d    = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                carry_d = digit_sum[DIGIT];
                a_sh_d  = a_next;
                b_sh_d  = b_sh_q >> DIGIT;
                count_d = count_q + CW'(1);
                // The final carry-out is dropped; overflow comes from the sign bits only.
                if (count_q == LAST) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    sum_d       = result;
                    overflow_d  = ov_raw;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            count_q     <= '0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            carry_q     <= carry_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign overflow  = overflow_q;

endmodule
